// File: rtl/add_sched_pkg.sv
// Shared constants and round-robin helpers for the add_rr_sched slice.
package add_sched_pkg;
  localparam int NREQ = 4;
  localparam int TAGW = 2;
  localparam int LAT  = 4;

  typedef struct packed {
    logic            hit;
    logic [TAGW-1:0] idx;
  } pick_t;

  function automatic logic [TAGW-1:0] rr_next(input logic [TAGW-1:0] idx);
    return idx + TAGW'(1);
  endfunction

  // Scan from farthest to nearest so the requester closest to ptr overwrites last.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [TAGW-1:0] ptr);
    pick_t           p;
    logic [TAGW-1:0] idx;
    p = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      idx = ptr + TAGW'(j);
      if (req[idx]) begin
        p.hit = 1'b1;
        p.idx = idx;
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/add_pipe3.sv
// Three-stage carry-split adder: per-slice sums, then two carry-resolution stages.
// ADD_RR_CARRY_OUT_EN adds a carry output from a widened MSB slice.
module add_pipe3 #(
  parameter int WIDTH  = 28,
  parameter int WIDTH1 = 9,
  parameter int WIDTH2 = 9,
  parameter int WIDTH3 = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
`ifdef ADD_RR_CARRY_OUT_EN
  , output logic           carry
`endif
);
`ifdef ADD_RR_CARRY_OUT_EN
  localparam int MW = WIDTH3 + 1;
`else
  localparam int MW = WIDTH3;
`endif

  logic [WIDTH1:0]   q1;
  logic [WIDTH2:0]   q2, v2;
  logic [MW-1:0]     q3, v3, s3;
  logic [WIDTH1-1:0] v1, s1;
  logic [WIDTH2-1:0] s2;

  // A carry out of the middle slice leaves at most 2^W2-2 behind, so v2 and
  // q2 can never both carry into the MSB slice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1 <= '0; q2 <= '0; q3 <= '0;
      v1 <= '0; v2 <= '0; v3 <= '0;
      s1 <= '0; s2 <= '0; s3 <= '0;
    end else begin
      q1 <= {1'b0, a[WIDTH1-1:0]} + {1'b0, b[WIDTH1-1:0]};
      q2 <= {1'b0, a[WIDTH1 +: WIDTH2]} + {1'b0, b[WIDTH1 +: WIDTH2]};
      q3 <= MW'(a[WIDTH1+WIDTH2 +: WIDTH3]) + MW'(b[WIDTH1+WIDTH2 +: WIDTH3]);
      v1 <= q1[WIDTH1-1:0];
      v2 <= {1'b0, q2[WIDTH2-1:0]} + (WIDTH2+1)'(q1[WIDTH1]);
      v3 <= q3 + MW'(q2[WIDTH2]);
      s1 <= v1;
      s2 <= v2[WIDTH2-1:0];
      s3 <= v3 + MW'(v2[WIDTH2]);
    end
  end

  assign sum = {s3[WIDTH3-1:0], s2, s1};
`ifdef ADD_RR_CARRY_OUT_EN
  assign carry = s3[WIDTH3];
`endif
endmodule

// File: rtl/add_rr_sched.sv
// Round-robin arbiter feeding one shared pipelined adder, with tags tracking each sum's owner.
// ADD_RR_CARRY_OUT_EN exposes res_carry, aligned with res_sum.
module add_rr_sched
  import add_sched_pkg::*;
#(
  parameter int WIDTH  = 28,
  parameter int WIDTH1 = 9,
  parameter int WIDTH2 = 9,
  parameter int WIDTH3 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] x_bus,
  input  logic [NREQ*WIDTH-1:0] y_bus,
  output logic [NREQ-1:0]       gnt,
  output logic                  res_valid,
  output logic [TAGW-1:0]       res_tag,
  output logic [WIDTH-1:0]      res_sum,
  output logic [NREQ-1:0]       res_done,
  output logic                  busy
`ifdef ADD_RR_CARRY_OUT_EN
  , output logic                res_carry
`endif
);
  logic [TAGW-1:0]           ptr;
  pick_t                     pick;
  logic                      grant;
  logic [WIDTH-1:0]          a_r, b_r;
  logic [LAT-1:0]            vld;
  logic [LAT-1:0][TAGW-1:0]  tag;

  always_comb begin
    pick  = rr_pick(req, ptr);
    gnt   = '0;
    grant = 1'b0;
    if (pick.hit && !reset) begin
      gnt[pick.idx] = 1'b1;
      grant         = 1'b1;
    end
  end

  // Operand and tag regs load only on a grant, so idle slots replay the last
  // operation and res_sum/res_tag naturally hold their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      a_r <= '0;
      b_r <= '0;
      vld <= '0;
      tag <= '0;
    end else begin
      vld <= {vld[LAT-2:0], grant};
      for (int i = 1; i < LAT; i++) tag[i] <= tag[i-1];
      if (grant) begin
        ptr    <= rr_next(pick.idx);
        a_r    <= x_bus[int'(pick.idx)*WIDTH +: WIDTH];
        b_r    <= y_bus[int'(pick.idx)*WIDTH +: WIDTH];
        tag[0] <= pick.idx;
      end
    end
  end

  add_pipe3 #(
    .WIDTH (WIDTH),
    .WIDTH1(WIDTH1),
    .WIDTH2(WIDTH2),
    .WIDTH3(WIDTH3)
  ) u_pipe (
    .clk  (clk),
    .reset(reset),
    .a    (a_r),
    .b    (b_r),
    .sum  (res_sum)
`ifdef ADD_RR_CARRY_OUT_EN
    , .carry(res_carry)
`endif
  );

  assign res_valid = vld[LAT-1];
  assign res_tag   = tag[LAT-1];
  assign res_done  = res_valid ? ({{(NREQ-1){1'b0}}, 1'b1} << res_tag) : '0;
  assign busy      = |vld;
endmodule

// File: tb/tb_add_rr_sched.sv
// Self-checking bench for add_rr_sched: vector table, directed corner sequences, random vs. model.
module tb_add_rr_sched;
  localparam int W = 28;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     req = '0;
  logic [4*W-1:0] x_bus = '0, y_bus = '0;
  logic [3:0]     gnt, res_done;
  logic           res_valid, busy;
  logic [1:0]     res_tag;
  logic [W-1:0]   res_sum;
`ifdef ADD_RR_CARRY_OUT_EN
  logic           res_carry;
`endif

  add_rr_sched dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .x_bus    (x_bus),
    .y_bus    (y_bus),
    .gnt      (gnt),
    .res_valid(res_valid),
    .res_tag  (res_tag),
    .res_sum  (res_sum),
    .res_done (res_done),
    .busy     (busy)
`ifdef ADD_RR_CARRY_OUT_EN
    , .res_carry(res_carry)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending results keyed by the cycle they are due.
  typedef struct {
    int         due;
    int         tag;
    logic [W:0] sum;
  } op_t;

  op_t        pend[$];
  int         mptr = 0, cyc = 0, last_tag = 0;
  logic [W:0] last_sum = '0;

  logic [3:0]   o_gnt;
  logic         o_valid, o_busy;
  logic [1:0]   o_tag;
  logic [W-1:0] o_sum;

  task automatic model_reset();
    pend.delete();
    mptr     = 0;
    last_sum = '0;
    last_tag = 0;
  endtask

  task automatic step(input logic [3:0] r, input logic [4*W-1:0] xb, input logic [4*W-1:0] yb);
    int          g;
    logic [63:0] s;
    req   = r;
    x_bus = xb;
    y_bus = yb;
    @(negedge clk);
    g = -1;
    for (int j = 0; j < 4; j++)
      if (g < 0 && r[(mptr + j) % 4]) g = (mptr + j) % 4;
    chk("gnt", gnt, (g < 0) ? 64'd0 : (64'd1 << g));
    chk("busy", busy, pend.size() > 0);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      last_sum = pend[0].sum;
      last_tag = pend[0].tag;
      chk("res_valid", res_valid, 1);
      chk("res_done", res_done, 64'd1 << last_tag);
      void'(pend.pop_front());
    end else begin
      chk("res_valid", res_valid, 0);
      chk("res_done", res_done, 0);
    end
    chk("res_tag", res_tag, last_tag);
    chk("res_sum", res_sum, last_sum[W-1:0]);
`ifdef ADD_RR_CARRY_OUT_EN
    chk("res_carry", res_carry, last_sum[W]);
`endif
    o_gnt = gnt; o_valid = res_valid; o_busy = busy; o_tag = res_tag; o_sum = res_sum;
    @(posedge clk);
    if (g >= 0) begin
      s = 64'(xb[g*W +: W]) + 64'(yb[g*W +: W]);
      pend.push_back('{cyc + 4, g, s[W:0]});
      mptr = (g + 1) % 4;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b1111;
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_tag", res_tag, 0);
    chk("rst_done", res_done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = '0;
    model_reset();
  endtask

  typedef struct packed {
    logic [3:0]   req;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [3:0]   exp_gnt;
    logic         exp_valid;
    logic [1:0]   exp_tag;
    logic [W-1:0] exp_sum;
    logic         exp_busy;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  logic [4*W-1:0] rx, ry;
  int             nvalid;

  initial begin
    tbl[0]  = '{4'b0001, 28'd5,       28'd7, 4'b0001, 1'b0, 2'd0, 28'd0,       1'b0};
    tbl[1]  = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b0, 2'd0, 28'd0,       1'b1};
    tbl[2]  = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b0, 2'd0, 28'd0,       1'b1};
    tbl[3]  = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b0, 2'd0, 28'd0,       1'b1};
    tbl[4]  = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b1, 2'd0, 28'd12,      1'b1};
    tbl[5]  = '{4'b1000, 28'h003FFFF, 28'd1, 4'b1000, 1'b0, 2'd0, 28'd12,      1'b0};
    tbl[6]  = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b0, 2'd0, 28'd12,      1'b1};
    tbl[7]  = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b0, 2'd0, 28'd12,      1'b1};
    tbl[8]  = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b0, 2'd0, 28'd12,      1'b1};
    tbl[9]  = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b1, 2'd3, 28'h0040000, 1'b1};
    tbl[10] = '{4'b0110, 28'hFFFFFFF, 28'd1, 4'b0010, 1'b0, 2'd3, 28'h0040000, 1'b0};
    tbl[11] = '{4'b0100, 28'hFFFFFFF, 28'd1, 4'b0100, 1'b0, 2'd3, 28'h0040000, 1'b1};
    tbl[12] = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b0, 2'd3, 28'h0040000, 1'b1};
    tbl[13] = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b0, 2'd3, 28'h0040000, 1'b1};
    tbl[14] = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b1, 2'd1, 28'd0,       1'b1};
    tbl[15] = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b1, 2'd2, 28'd0,       1'b1};
    tbl[16] = '{4'b0000, 28'd0,       28'd0, 4'b0000, 1'b0, 2'd2, 28'd0,       1'b0};

    #1;
    do_reset();

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].req, {4{tbl[i].x}}, {4{tbl[i].y}});
      chk($sformatf("tbl%0d_gnt", i), o_gnt, tbl[i].exp_gnt);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_tag", i), o_tag, tbl[i].exp_tag);
      chk($sformatf("tbl%0d_sum", i), o_sum, tbl[i].exp_sum);
      chk($sformatf("tbl%0d_busy", i), o_busy, tbl[i].exp_busy);
    end

    // All four requesting continuously from ptr=0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        rx[k*W +: W] = W'($urandom);
        ry[k*W +: W] = W'($urandom);
      end
      step(4'b1111, rx, ry);
      chk($sformatf("rr_all_%0d", i), o_gnt, 64'd1 << (i % 4));
    end
    for (int i = 0; i < 5; i++) step(4'b0000, '0, '0);

    // Fairness around a moved pointer.
    step(4'b0010, {4{28'd3}}, {4{28'd4}});
    chk("fair_setup", o_gnt, 4'b0010);
    step(4'b0011, {4{28'd3}}, {4{28'd4}});
    chk("fair_0011_a", o_gnt, 4'b0001);
    step(4'b0010, {4{28'd3}}, {4{28'd4}});
    chk("fair_0011_b", o_gnt, 4'b0010);
    step(4'b0101, {4{28'd9}}, {4{28'd1}});
    chk("fair_0101_a", o_gnt, 4'b0100);
    step(4'b0001, {4{28'd9}}, {4{28'd1}});
    chk("fair_0101_b", o_gnt, 4'b0001);

    // Idle: pointer must hold at 1.
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, '0, '0);
      chk("idle_gnt", o_gnt, 0);
    end
    step(4'b1111, {4{28'd2}}, {4{28'd2}});
    chk("idle_ptr_hold", o_gnt, 4'b0010);
    for (int i = 0; i < 5; i++) step(4'b0000, '0, '0);

    // Reset while operations are in flight.
    do_reset();
    step(4'b0001, {4{28'd100}}, {4{28'd1}});
    step(4'b0010, {4{28'd200}}, {4{28'd1}});
    reset = 1'b1;
    req   = 4'b0100;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_valid", res_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(4'b1000, {4{28'd77}}, {4{28'd3}});
    chk("post_rst_gnt", o_gnt, 4'b1000);
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'b0000, '0, '0);
      if (o_valid) nvalid++;
    end
    chk("post_rst_nvalid", nvalid, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) begin
        rx[k*W +: W] = W'($urandom);
        ry[k*W +: W] = W'($urandom);
      end
      step(4'($urandom_range(0, 15)), rx, ry);
    end
    for (int i = 0; i < 6; i++) step(4'b0000, '0, '0);
    chk("drain_empty", pend.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
